store_buffer: RTL and testbench

STORE_BUFFER -- requirements
Module: store_buffer

---
 rtl/store_buffer_if.sv | 31 +++
 rtl/store_buffer.sv | 97 +++++++++
 tb/tb_store_buffer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_if.sv
// Request, load-result and data-memory signals of the store buffer bundled in one interface.
// Handshake: a request transfers on a rising clk edge where req_valid && req_ready; req_ready may depend on req_we.
interface store_buffer_if #(
  parameter int WORD_LEN = 16
);
  logic                req_valid;
  logic                req_we;
  logic [WORD_LEN-1:0] req_addr;
  logic [WORD_LEN-1:0] req_wdata;
  logic                req_ready;
  logic                ld_valid;
  logic [WORD_LEN-1:0] ld_data;
  logic                mem_writeEn;
  logic                mem_readEn;
  logic [WORD_LEN-1:0] mem_address;
  logic [WORD_LEN-1:0] mem_dataIn;
  logic [WORD_LEN-1:0] mem_dataOut;
  logic                sb_empty;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_dataOut,
    input  req_ready, ld_valid, ld_data, mem_writeEn, mem_readEn,
           mem_address, mem_dataIn, sb_empty
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_dataOut,
    output req_ready, ld_valid, ld_data, mem_writeEn, mem_readEn,
           mem_address, mem_dataIn, sb_empty
  );
endinterface

// File: rtl/store_buffer.sv
// Store buffer: stores queue in a circular FIFO and drain whenever no load owns the memory port;
// loads forward from the youngest matching buffered store and are starvation-limited.
module store_buffer #(
  parameter int WORD_LEN     = 16,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 4
) (
  input logic           clk,
  input logic           rst,
  store_buffer_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  logic [WORD_LEN-1:0] addr_q [DEPTH];
  logic [WORD_LEN-1:0] data_q [DEPTH];
  logic [PW-1:0]       head;
  logic [PW-1:0]       tail;
  logic [CW-1:0]       count;
  logic [SW-1:0]       starve;

  logic                nonempty;
  logic                store_ready;
  logic                load_ready;
  logic                push;
  logic                load_acc;
  logic                drain;
  logic                fwd_hit;
  logic [WORD_LEN-1:0] fwd_data;
  logic [WORD_LEN-1:0] load_result;
  logic [PW-1:0]       idx;

  always_comb begin
    nonempty    = (count != '0);
    store_ready = (count < CW'(DEPTH));
    load_ready  = !((starve == SW'(STARVE_LIMIT)) && nonempty);
    push        = !rst && bus.req_valid && bus.req_we && store_ready;
    load_acc    = !rst && bus.req_valid && !bus.req_we && load_ready;
    // Any non-empty cycle the load does not claim is a drain cycle.
    drain       = !rst && nonempty && !load_acc;
  end

  // Walk entries oldest to youngest so the last hit is the youngest store.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    idx      = head;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + PW'(i);
      if ((CW'(i) < count) && (addr_q[idx] == bus.req_addr)) begin
        fwd_hit  = 1'b1;
        fwd_data = data_q[idx];
      end
    end
    load_result = fwd_hit ? fwd_data : bus.mem_dataOut;
  end

  assign bus.req_ready   = bus.req_we ? store_ready : load_ready;
  assign bus.sb_empty    = !nonempty;
  assign bus.mem_readEn  = load_acc;
  assign bus.mem_writeEn = drain;
  assign bus.mem_address = load_acc ? bus.req_addr : addr_q[head];
  assign bus.mem_dataIn  = data_q[head];

  always_ff @(posedge clk) begin
    if (push) begin
      addr_q[tail] <= bus.req_addr;
      data_q[tail] <= bus.req_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      head         <= '0;
      tail         <= '0;
      count        <= '0;
      starve       <= '0;
      bus.ld_valid <= 1'b0;
      bus.ld_data  <= '0;
    end else begin
      if (push)  tail <= tail + PW'(1);
      if (drain) head <= head + PW'(1);
      unique case ({push, drain})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (drain || !nonempty)
        starve <= '0;
      else if (load_acc && (starve != SW'(STARVE_LIMIT)))
        starve <= starve + SW'(1);
      bus.ld_valid <= load_acc;
      if (load_acc) bus.ld_data <= load_result;
    end
  end
endmodule

// File: tb/tb_store_buffer.sv
// Randomized and directed bench for store_buffer against a queue-based model of the buffer and memory.
module tb_store_buffer;
  localparam int W     = 16;
  localparam int DEPTH = 4;
  localparam int LIMIT = 4;

  typedef struct packed {
    logic [W-1:0] addr;
    logic [W-1:0] data;
  } entry_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  store_buffer_if #(.WORD_LEN(W)) bus ();

  store_buffer #(
    .WORD_LEN(W), .DEPTH(DEPTH), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // data memory seen by the DUT (written from DUT write strobes) and the model's memory
  logic [W-1:0] dmem    [256];
  logic [W-1:0] ref_mem [256];
  assign bus.mem_dataOut = dmem[bus.mem_address[7:0]];

  // model state
  entry_t       sbq[$];
  logic [W-1:0] exp_q[$];
  int           starve;
  logic         ld_pending;
  logic [W-1:0] exp_ld_data;

  int n_pass  = 0;
  int n_total = 0;
  bit chk_en  = 1'b0;

  // observed outputs of the last step, for directed literal checks
  logic         obs_ready, obs_empty, obs_wen, obs_ren, obs_ld_valid;
  logic [W-1:0] obs_addr, obs_din, obs_ld_data;

  function automatic logic [W-1:0] init_val(input int i);
    return (i == 8'h40) ? 16'h5A5A : {8'hA5, 8'(i)};
  endfunction

  task automatic check_word(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got 0x%h expected 0x%h at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    else n_pass++;
  endtask

  // driver + per-cycle compare + model update for one clock
  task automatic step(input logic v, input logic we, input logic [W-1:0] a,
                      input logic [W-1:0] d, input logic r);
    logic         nonempty, exp_ready, acc_load, acc_store, drain;
    logic [W-1:0] res;
    @(negedge clk);
    rst           = r;
    bus.req_valid = v;
    bus.req_we    = we;
    bus.req_addr  = a;
    bus.req_wdata = d;
    #1;
    nonempty  = (sbq.size() > 0);
    exp_ready = we ? (sbq.size() < DEPTH) : !((starve == LIMIT) && nonempty);
    acc_load  = !r && v && !we && exp_ready;
    acc_store = !r && v && we && exp_ready;
    drain     = !r && nonempty && !acc_load;
    res = ref_mem[a[7:0]];
    foreach (sbq[i]) if (sbq[i].addr == a) res = sbq[i].data;

    obs_ready    = bus.req_ready;
    obs_empty    = bus.sb_empty;
    obs_wen      = bus.mem_writeEn;
    obs_ren      = bus.mem_readEn;
    obs_addr     = bus.mem_address;
    obs_din      = bus.mem_dataIn;
    obs_ld_valid = bus.ld_valid;
    obs_ld_data  = bus.ld_data;

    if (chk_en) begin
      if (!r && v) check_bit("req_ready", obs_ready, exp_ready);
      check_bit("sb_empty", obs_empty, !nonempty);
      check_bit("mem_readEn", obs_ren, acc_load);
      check_bit("mem_writeEn", obs_wen, drain);
      if (acc_load) check_word("load_address", obs_addr, a);
      if (drain) begin
        check_word("drain_address", obs_addr, sbq[0].addr);
        check_word("drain_data", obs_din, sbq[0].data);
      end
      if (ld_pending) begin
        exp_ld_data = exp_q.pop_front();
        check_bit("ld_valid", obs_ld_valid, 1'b1);
        check_word("ld_data", obs_ld_data, exp_ld_data);
      end else begin
        check_bit("ld_valid", obs_ld_valid, 1'b0);
        check_word("ld_data_hold", obs_ld_data, exp_ld_data);
      end
    end

    @(posedge clk);
    if (obs_wen) dmem[obs_addr[7:0]] = obs_din;
    if (r) begin
      sbq.delete();
      exp_q.delete();
      starve      = 0;
      ld_pending  = 1'b0;
      exp_ld_data = '0;
    end else begin
      if (drain) begin
        ref_mem[sbq[0].addr[7:0]] = sbq[0].data;
        void'(sbq.pop_front());
      end
      if (acc_store) sbq.push_back('{addr: a, data: d});
      if (drain || !nonempty) starve = 0;
      else if (acc_load && starve < LIMIT) starve++;
      ld_pending = acc_load;
      if (acc_load) exp_q.push_back(res);
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, 1'b0);
  endtask

  initial begin
    int           n_loads;
    logic         stall_wen;
    logic [7:0]   lo;
    int           mism;

    for (int i = 0; i < 256; i++) begin
      dmem[i]    = init_val(i);
      ref_mem[i] = init_val(i);
    end
    starve      = 0;
    ld_pending  = 1'b0;
    exp_ld_data = '0;
    rst = 1'b1;
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_addr = '0; bus.req_wdata = '0;

    step(1'b0, 1'b0, '0, '0, 1'b1);
    chk_en = 1'b1;
    step(1'b0, 1'b0, '0, '0, 1'b1);
    idle();
    check_bit("reset_sb_empty", obs_empty, 1'b1);
    check_bit("reset_ld_valid", obs_ld_valid, 1'b0);
    check_word("reset_ld_data", obs_ld_data, 16'h0000);

    // single store drains the next cycle
    step(1'b1, 1'b1, 16'h0010, 16'hBEEF, 1'b0);
    idle();
    check_bit("drain1_wen", obs_wen, 1'b1);
    check_word("drain1_addr", obs_addr, 16'h0010);
    check_word("drain1_data", obs_din, 16'hBEEF);
    idle();
    check_bit("drain1_empty_after", obs_empty, 1'b1);
    check_word("drain1_mem", dmem[8'h10], 16'hBEEF);

    // youngest store forwarded to a following load
    step(1'b1, 1'b1, 16'h0020, 16'h1111, 1'b0);
    step(1'b1, 1'b1, 16'h0020, 16'h2222, 1'b0);
    step(1'b1, 1'b0, 16'h0020, 16'h0000, 1'b0);
    check_bit("fwd_load_readEn", obs_ren, 1'b1);
    check_bit("fwd_load_no_drain", obs_wen, 1'b0);
    idle();
    check_bit("fwd_ld_valid", obs_ld_valid, 1'b1);
    check_word("fwd_ld_data", obs_ld_data, 16'h2222);
    idle();

    // load starvation limit forces a drain
    step(1'b1, 1'b1, 16'h0050, 16'h1234, 1'b0);
    n_loads   = 0;
    stall_wen = 1'b0;
    for (int k = 0; k < 10; k++) begin
      step(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
      if (!obs_ready) begin
        stall_wen = obs_wen;
        break;
      end
      n_loads++;
    end
    check_word("starve_loads_accepted", W'(n_loads), 16'd4);
    check_bit("starve_drain", stall_wen, 1'b1);
    step(1'b1, 1'b0, 16'h0040, 16'h0000, 1'b0);
    check_bit("starve_resume_ready", obs_ready, 1'b1);
    idle();
    check_bit("starve_ld_valid", obs_ld_valid, 1'b1);
    check_word("starve_ld_data", obs_ld_data, 16'h5A5A);

    // reset discards a buffered store
    step(1'b1, 1'b1, 16'h0060, 16'h7777, 1'b0);
    step(1'b0, 1'b0, '0, '0, 1'b1);
    check_bit("rst_no_write", obs_wen, 1'b0);
    idle();
    check_bit("rst_sb_empty", obs_empty, 1'b1);
    check_bit("rst_ld_valid", obs_ld_valid, 1'b0);
    check_bit("rst_no_write_after", obs_wen, 1'b0);
    check_word("rst_mem_untouched", dmem[8'h60], 16'hA560);

    // randomized traffic over a small, aliasing address set
    for (int c = 0; c < 3000; c++) begin
      lo = 8'($urandom_range(0, 7)) | (($urandom_range(0, 1) == 1) ? 8'h80 : 8'h00);
      step($urandom_range(0, 99) < 85, $urandom_range(0, 99) < 35,
           {8'h00, lo}, 16'($urandom), $urandom_range(0, 99) < 2);
    end
    for (int c = 0; c < 4; c++) idle();

    mism = 0;
    for (int i = 0; i < 256; i++) if (dmem[i] !== ref_mem[i]) mism++;
    check_word("final_memory_mismatches", W'(mism), 16'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
